// File: rtl/riscv_id_decode_ctrl_if.sv
// Fetch-to-execute handshake bundle for the decode controller.
// The controller sits on the slave modport; fetch/execute (or a bench) use master.
interface riscv_id_decode_ctrl_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
);
    logic                   i_valid;
    logic                   o_ready;
    logic [INSTR_WIDTH-1:0] i_instr;
    logic [DATA_WIDTH-1:0]  i_pc;
    logic                   i_flush;
    logic                   o_valid;
    logic                   i_ready;
    logic [INSTR_WIDTH-1:0] o_instr;
    logic [DATA_WIDTH-1:0]  o_pc;
    logic [2:0]             o_imm_sel;
    logic [DATA_WIDTH-1:0]  o_imm_data;
    logic                   o_illegal;

    modport master (
        output i_valid, i_instr, i_pc, i_flush, i_ready,
        input  o_ready, o_valid, o_instr, o_pc, o_imm_sel, o_imm_data, o_illegal
    );

    modport slave (
        input  i_valid, i_instr, i_pc, i_flush, i_ready,
        output o_ready, o_valid, o_instr, o_pc, o_imm_sel, o_imm_data, o_illegal
    );
endinterface

// File: rtl/riscv_id_decode_ctrl.sv
// RISC-V decode-stage controller: opcode decode, immediate generation and a
// 2-entry skid buffer (OUT + SKID) feeding the ID/EX boundary.
package riscv_pkg;
    localparam logic [2:0] IMM_I_TYPE = 3'd0;
    localparam logic [2:0] IMM_S_TYPE = 3'd1;
    localparam logic [2:0] IMM_B_TYPE = 3'd2;
    localparam logic [2:0] IMM_U_TYPE = 3'd3;
    localparam logic [2:0] IMM_J_TYPE = 3'd4;
    localparam logic [2:0] IMM_NONE   = 3'd7;
endpackage

module riscv_id_imm_gen
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [31:7]           instr,
    input  logic [2:0]            imm_sel,
    output logic [DATA_WIDTH-1:0] imm_data
);
    always_comb begin
        unique case (imm_sel)
            IMM_I_TYPE: imm_data = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
            IMM_S_TYPE: imm_data = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B_TYPE: imm_data = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                                    instr[30:25], instr[11:8], 1'b0};
            IMM_U_TYPE: imm_data = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'b0};
            IMM_J_TYPE: imm_data = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                                    instr[20], instr[30:21], 1'b0};
            default:    imm_data = '0;
        endcase
    end
endmodule

module riscv_id_decode_ctrl
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
) (
    input logic                   i_clk,
    input logic                   i_rst,
    riscv_id_decode_ctrl_if.slave bus
);
    // State encoding is {SKID valid, OUT valid}.
    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_ONE   = 2'b01;
    localparam logic [1:0] S_FULL  = 2'b11;

    logic [1:0] state, state_next;
    logic       ready_q;
    logic       accept, drain;
    logic       load_out, out_from_skid, load_skid;

    logic [2:0]             dec_sel;
    logic                   dec_illegal;
    logic [DATA_WIDTH-1:0]  dec_imm;

    logic [INSTR_WIDTH-1:0] out_instr, skid_instr;
    logic [DATA_WIDTH-1:0]  out_pc, skid_pc;
    logic [DATA_WIDTH-1:0]  out_imm, skid_imm;
    logic [2:0]             out_sel, skid_sel;
    logic                   out_illegal, skid_illegal;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        dec_sel     = IMM_NONE;
        dec_illegal = 1'b0;
        unique case (bus.i_instr[6:0])
            7'b0000011, 7'b0010011, 7'b0011011,
            7'b1100111, 7'b1110011:             dec_sel = IMM_I_TYPE;
            7'b0100011:                         dec_sel = IMM_S_TYPE;
            7'b0110111, 7'b0010111:             dec_sel = IMM_U_TYPE;
            7'b1101111:                         dec_sel = IMM_J_TYPE;
            7'b1100011:                         dec_sel = IMM_B_TYPE;
            7'b0110011, 7'b0111011:             dec_sel = IMM_NONE;
            default:                            dec_illegal = 1'b1;
        endcase
    end

    riscv_id_imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
        .instr    (bus.i_instr[31:7]),
        .imm_sel  (dec_sel),
        .imm_data (dec_imm)
    );

    assign accept = bus.i_valid & ready_q;
    assign drain  = state[0] & bus.i_ready;

    always_comb begin
        state_next    = state;
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            S_EMPTY: if (accept) begin
                state_next = S_ONE;
                load_out   = 1'b1;
            end
            S_ONE: begin
                if (accept && drain) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_next = S_FULL;
                    load_skid  = 1'b1;
                end else if (drain) begin
                    state_next = S_EMPTY;
                end
            end
            S_FULL: if (drain) begin
                state_next    = S_ONE;
                load_out      = 1'b1;
                out_from_skid = 1'b1;
            end
            default: state_next = S_EMPTY;
        endcase
        // Flush empties the buffer; a drain this cycle has already been taken downstream.
        if (bus.i_flush) state_next = S_EMPTY;
    end

    // ready is a pure function of next occupancy, so i_ready never reaches o_ready combinationally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= ~state_next[1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_instr   <= '0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_sel     <= IMM_NONE;
            out_illegal <= 1'b0;
        end else if (load_out) begin
            out_instr   <= out_from_skid ? skid_instr   : bus.i_instr;
            out_pc      <= out_from_skid ? skid_pc      : bus.i_pc;
            out_imm     <= out_from_skid ? skid_imm     : dec_imm;
            out_sel     <= out_from_skid ? skid_sel     : dec_sel;
            out_illegal <= out_from_skid ? skid_illegal : dec_illegal;
        end
    end

    // NOTE: skid payload has no reset; it is only observed after a load, gated by state[1].
    always_ff @(posedge i_clk) begin
        if (load_skid) begin
            skid_instr   <= bus.i_instr;
            skid_pc      <= bus.i_pc;
            skid_imm     <= dec_imm;
            skid_sel     <= dec_sel;
            skid_illegal <= dec_illegal;
        end
    end

    assign bus.o_ready    = ready_q;
    assign bus.o_valid    = state[0];
    assign bus.o_instr    = out_instr;
    assign bus.o_pc       = out_pc;
    assign bus.o_imm_sel  = out_sel;
    assign bus.o_imm_data = out_imm;
    assign bus.o_illegal  = out_illegal;
endmodule
